// File: rtl/sample_packetiser.sv
// Sample packetiser: buffers 16-bit capture samples in a FIFO and frames them
// as SYNC/DEST/LEN/payload byte packets for a UART transmitter.
module sample_packetiser #(
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned PAYLOAD_SAMPLES = 8,
    parameter logic [7:0]  SYNC_BYTE       = 8'h55,
    parameter logic [7:0]  DEST_ADDR       = 8'h01
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic [15:0] ipSample,
    input  logic        ipValid,
    output logic [7:0]  opTxData,
    output logic        opTxValid,
    input  logic        ipTxReady,
    output logic [15:0] opFIFO_Size,
    output logic        opOverflow,
    input  logic        ipClearOverflow
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned SCW = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DEST    = 3'd2,
        LEN     = 3'd3,
        DATA_HI = 3'd4,
        DATA_LO = 3'd5
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW-1:0]    headIdx;
    logic [15:0]      headWord;
    logic [CW-1:0]    count;
    logic [SCW-1:0]   sampleCnt;
    logic             txHs;
    logic             pop;
    logic             wrEn;
    logic             lastSample;
    logic [7:0]       txDataNext;
    logic             txValidNext;

    assign txHs       = opTxValid && ipTxReady;
    assign pop        = txHs && (state == DATA_LO);
    // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken.
    assign wrEn       = ipValid && ((count != CW'(FIFO_DEPTH)) || pop);
    assign lastSample = (sampleCnt == SCW'(PAYLOAD_SAMPLES - 1));
    assign opFIFO_Size = 16'(count);

    // State register
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (32'(count) >= PAYLOAD_SAMPLES) stateNext = SYNC;
            SYNC:    if (txHs) stateNext = DEST;
            DEST:    if (txHs) stateNext = LEN;
            LEN:     if (txHs) stateNext = DATA_HI;
            DATA_HI: if (txHs) stateNext = DATA_LO;
            DATA_LO: if (txHs) stateNext = lastSample ? IDLE : DATA_HI;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: the byte for the upcoming state, registered below
    always_comb begin
        headIdx     = pop ? (rdPtr + AW'(1)) : rdPtr;
        headWord    = mem[headIdx];
        txValidNext = (stateNext != IDLE);
        txDataNext  = 8'h00;
        case (stateNext)
            SYNC:    txDataNext = SYNC_BYTE;
            DEST:    txDataNext = DEST_ADDR;
            LEN:     txDataNext = 8'(2 * PAYLOAD_SAMPLES);
            DATA_HI: txDataNext = headWord[15:8];
            DATA_LO: txDataNext = headWord[7:0];
            default: txDataNext = 8'h00;
        endcase
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            opTxValid <= 1'b0;
            opTxData  <= 8'h00;
        end else begin
            opTxValid <= txValidNext;
            opTxData  <= txDataNext;
        end
    end

    // Sample storage; contents are don't-care until written
    always_ff @(posedge ipClk) begin
        if (wrEn) begin
            mem[wrPtr] <= ipSample;
        end
    end

    // FIFO pointers, occupancy, payload counter and sticky overflow
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            sampleCnt  <= '0;
            opOverflow <= 1'b0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({wrEn, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (state == IDLE && stateNext == SYNC) begin
                sampleCnt <= '0;
            end else if (pop) begin
                sampleCnt <= sampleCnt + SCW'(1);
            end
            if (ipValid && !wrEn) begin
                opOverflow <= 1'b1;
            end else if (ipClearOverflow) begin
                opOverflow <= 1'b0;
            end
        end
    end

endmodule
